// File: rtl/cim_seq_pkg.sv
// Shared types and sizing helpers for the CIM stack sequencer.
// Holds the sequencer state enum and the functions that derive the number
// of weight beats per output vector and the width of the beat counter.
package cim_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    RESULT,
    DONE
  } seq_state_t;

  // Weight beats needed per dot product: one beat per bit per SRAM cycle.
  function automatic int calc_beats(input int num_inputs, input int throughput);
    return num_inputs * throughput;
  endfunction

  // Beat counter gets one spare bit so BEATS itself is representable.
  function automatic int calc_beat_w(input int num_inputs, input int throughput);
    return $clog2(num_inputs * throughput) + 1;
  endfunction

endpackage

// File: rtl/cim_seq_perf_counters.sv
// Saturating performance counters for the CIM stack sequencer.
// Only instantiated when CIM_SEQ_PERF_CNT_EN is defined. Counts busy cycles
// and stall cycles; both stick at all-ones and clear only on reset.
module cim_seq_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        busy,
  input  logic        stall,
  output logic [31:0] perf_busy_cycles,
  output logic [31:0] perf_stall_cycles
);

  // Count qualifying cycles, holding at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && !(&perf_busy_cycles)) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
      if (stall && !(&perf_stall_cycles)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end

endmodule

// File: rtl/cim_stack_sequencer.sv
// Job-level controller for the multi-stack CIM datapath.
// Loads activations and the stage-4 scale once per job, streams weight beats
// for each output vector (freezing the pipe on weight stalls), drains the
// pipeline latency and hands each result out under valid/ready.
// Optional feature macro: CIM_SEQ_PERF_CNT_EN adds busy/stall counters.
module cim_stack_sequencer #(
  parameter int NUM_STACKS         = 8,
  parameter int STAGE_1_NUM_INPUTS = 8,
  parameter int SRAM_THROUGHPUT    = 1,
  parameter int STAGE_4_BIT_WIDTH  = 4,
  parameter int PIPE_LATENCY       = 4,
  parameter int LEN_W              = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [LEN_W-1:0]             cmd_len,
  input  logic [STAGE_4_BIT_WIDTH-1:0] cmd_scale,
  output logic                         act_wr_en,
  output logic                         queue_wr_en,
  output logic [STAGE_4_BIT_WIDTH-1:0] queue_wr_data,
  output logic                         flop_en,
  output logic                         wt_req,
  input  logic                         wt_valid,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [LEN_W-1:0]             res_idx,
  output logic                         busy,
  output logic                         done
`ifdef CIM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_busy_cycles,
  output logic [31:0]                  perf_stall_cycles
`endif
);

  import cim_seq_pkg::*;

  localparam int BEATS   = calc_beats(STAGE_1_NUM_INPUTS, SRAM_THROUGHPUT);
  localparam int BEAT_W  = calc_beat_w(STAGE_1_NUM_INPUTS, SRAM_THROUGHPUT);
  localparam int DRAIN_W = $clog2(PIPE_LATENCY) + 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_LATENCY - 1);

  // All NUM_STACKS stacks share these enables; the count only needs to be sane.
  if (PIPE_LATENCY < 1 || NUM_STACKS < 1) begin : g_bad_params
    $error("cim_stack_sequencer: PIPE_LATENCY and NUM_STACKS must be >= 1");
  end

  seq_state_t                   state, state_n;
  logic [BEAT_W-1:0]            beat_cnt, beat_cnt_n;
  logic [DRAIN_W-1:0]           drain_cnt, drain_cnt_n;
  logic [LEN_W-1:0]             res_idx_n;
  logic [LEN_W-1:0]             len_q, len_n;
  logic [STAGE_4_BIT_WIDTH-1:0] scale_q, scale_n;
  logic [LEN_W:0]               idx_plus_one;

  assign idx_plus_one = {1'b0, res_idx} + {{LEN_W{1'b0}}, 1'b1};

  // Next-state, counter updates and Moore/Mealy outputs for the job FSM.
  always_comb begin
    state_n       = state;
    beat_cnt_n    = beat_cnt;
    drain_cnt_n   = drain_cnt;
    res_idx_n     = res_idx;
    len_n         = len_q;
    scale_n       = scale_q;
    cmd_ready     = 1'b0;
    act_wr_en     = 1'b0;
    queue_wr_en   = 1'b0;
    queue_wr_data = '0;
    flop_en       = 1'b0;
    wt_req        = 1'b0;
    res_valid     = 1'b0;
    done          = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          len_n   = cmd_len;
          scale_n = cmd_scale;
          state_n = (cmd_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        act_wr_en     = 1'b1;
        queue_wr_en   = 1'b1;
        queue_wr_data = scale_q;
        beat_cnt_n    = '0;
        res_idx_n     = '0;
        state_n       = STREAM;
      end
      STREAM: begin
        wt_req  = 1'b1;
        flop_en = wt_valid;
        if (wt_valid) begin
          beat_cnt_n = beat_cnt + 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            drain_cnt_n = '0;
            state_n     = DRAIN;
          end
        end
      end
      DRAIN: begin
        flop_en = 1'b1;
        if (drain_cnt == LAST_DRAIN) begin
          state_n = RESULT;
        end else begin
          drain_cnt_n = drain_cnt + 1'b1;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (idx_plus_one < {1'b0, len_q}) begin
            res_idx_n  = idx_plus_one[LEN_W-1:0];
            beat_cnt_n = '0;
            state_n    = STREAM;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and job registers; reset abandons any job without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      res_idx   <= '0;
      len_q     <= '0;
      scale_q   <= '0;
    end else begin
      state     <= state_n;
      beat_cnt  <= beat_cnt_n;
      drain_cnt <= drain_cnt_n;
      res_idx   <= res_idx_n;
      len_q     <= len_n;
      scale_q   <= scale_n;
    end
  end

`ifdef CIM_SEQ_PERF_CNT_EN
  logic stall_cycle;

  assign stall_cycle = ((state == STREAM) && !wt_valid) ||
                       ((state == RESULT) && !res_ready);

  cim_seq_perf_counters u_perf (
    .clk               (clk),
    .reset             (reset),
    .busy              (busy),
    .stall             (stall_cycle),
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
  );
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_cim_stack_sequencer.sv
// Self-checking bench for cim_stack_sequencer.
// A cycle timeline is derived from the job rules (LOAD, BEATS consumed
// beats, PIPE_LATENCY drain cycles, result held until accepted, DONE) and
// every cycle's outputs are compared against it; directed scenarios also
// check absolute event times. Build with CIM_SEQ_PERF_CNT_EN to include the
// performance counter ports.
module tb_cim_stack_sequencer;

  localparam int BEATS = 8;
  localparam int PL    = 4;
  localparam int MAXC  = 512;

  localparam logic [7:0] F_CMD_READY = 8'h80;
  localparam logic [7:0] F_BUSY      = 8'h40;
  localparam logic [7:0] F_ACT       = 8'h20;
  localparam logic [7:0] F_QWR       = 8'h10;
  localparam logic [7:0] F_FLOP      = 8'h08;
  localparam logic [7:0] F_WTREQ     = 8'h04;
  localparam logic [7:0] F_RESV      = 8'h02;
  localparam logic [7:0] F_DONE      = 8'h01;
  localparam logic [7:0] F_IDLE      = F_CMD_READY;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_len;
  logic [3:0] cmd_scale;
  logic       act_wr_en;
  logic       queue_wr_en;
  logic [3:0] queue_wr_data;
  logic       flop_en;
  logic       wt_req;
  logic       wt_valid;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_idx;
  logic       busy;
  logic       done;
`ifdef CIM_SEQ_PERF_CNT_EN
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_stall_cycles;
`endif

  int tests = 0;
  int fails = 0;

  logic       wv [MAXC];
  logic       rr [MAXC];
  logic [7:0] exp_flags [MAXC];
  logic [3:0] exp_qdata [MAXC];
  int         exp_idx [MAXC];

  int obs_first [16];
  int obs_act;
  int obs_done;

  cim_stack_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .cmd_scale     (cmd_scale),
    .act_wr_en     (act_wr_en),
    .queue_wr_en   (queue_wr_en),
    .queue_wr_data (queue_wr_data),
    .flop_en       (flop_en),
    .wt_req        (wt_req),
    .wt_valid      (wt_valid),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_idx       (res_idx),
    .busy          (busy),
    .done          (done)
`ifdef CIM_SEQ_PERF_CNT_EN
    ,
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Free-running 10 time-unit clock.
  always #5 clk = ~clk;

  function automatic logic [7:0] dut_flags();
    return {cmd_ready, busy, act_wr_en, queue_wr_en, flop_en, wt_req, res_valid, done};
  endfunction

  task automatic fill_patterns(input int stall_pct, input int hold_pct);
    for (int c = 0; c < MAXC; c++) begin
      if (c < 300) begin
        wv[c] = ($urandom_range(0, 99) >= stall_pct);
        rr[c] = ($urandom_range(0, 99) >= hold_pct);
      end else begin
        wv[c] = 1'b1;
        rr[c] = 1'b1;
      end
    end
  endtask

  // Expected per-cycle timeline; cycle 0 is the command handshake cycle.
  task automatic build_model(input int len, input logic [3:0] scale, output int last);
    int  c;
    int  n;
    logic acc;
    for (int i = 0; i < MAXC; i++) begin
      exp_flags[i] = 8'h00;
      exp_qdata[i] = 4'h0;
      exp_idx[i]   = -1;
    end
    exp_flags[0] = F_IDLE;
    if (len == 0) begin
      exp_flags[1] = F_BUSY | F_DONE;
      exp_flags[2] = F_IDLE;
      last = 2;
    end else begin
      exp_flags[1] = F_BUSY | F_ACT | F_QWR;
      exp_qdata[1] = scale;
      c = 2;
      for (int v = 0; v < len; v++) begin
        n = 0;
        while (n < BEATS) begin
          exp_flags[c] = F_BUSY | F_WTREQ | (wv[c] ? F_FLOP : 8'h00);
          if (wv[c]) n++;
          c++;
        end
        for (int d = 0; d < PL; d++) begin
          exp_flags[c] = F_BUSY | F_FLOP;
          c++;
        end
        acc = 1'b0;
        while (!acc) begin
          exp_flags[c] = F_BUSY | F_RESV;
          exp_idx[c]   = v;
          acc          = rr[c];
          c++;
        end
      end
      exp_flags[c]     = F_BUSY | F_DONE;
      exp_flags[c + 1] = F_IDLE;
      last = c + 1;
    end
  endtask

  task automatic run_job(input int len, input logic [3:0] scale, input string name);
    int last;
    build_model(len, scale, last);
    for (int i = 0; i < 16; i++) obs_first[i] = -1;
    obs_act  = 0;
    obs_done = -1;
    for (int c = 0; c <= last; c++) begin
      if (c == 0) begin
        cmd_valid = 1'b1;
        cmd_len   = 8'(len);
        cmd_scale = scale;
      end else if (c == last) begin
        cmd_valid = 1'b0;
      end else begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_len   = 8'($urandom);
        cmd_scale = 4'($urandom);
      end
      wt_valid  = wv[c];
      res_ready = rr[c];
      @(negedge clk);
      tests++;
      if ({dut_flags(), queue_wr_data} !== {exp_flags[c], exp_qdata[c]}) begin
        fails++;
        $display("[TB] FAIL %s cycle %0d flags/qdata: got %b/%h expected %b/%h",
                 name, c, dut_flags(), queue_wr_data, exp_flags[c], exp_qdata[c]);
      end
      if (exp_idx[c] >= 0) begin
        tests++;
        if (res_idx !== 8'(exp_idx[c])) begin
          fails++;
          $display("[TB] FAIL %s cycle %0d res_idx: got %0d expected %0d",
                   name, c, res_idx, exp_idx[c]);
        end
      end
      if (res_valid === 1'b1 && res_idx < 8'd16 && obs_first[res_idx] < 0) obs_first[res_idx] = c;
      if (act_wr_en === 1'b1) obs_act++;
      if (done === 1'b1 && obs_done < 0) obs_done = c;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    wt_valid  = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = 8'd3;
    cmd_scale = 4'h9;
    wt_valid  = 1'b1;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({dut_flags(), queue_wr_data, res_idx} !== {F_IDLE, 4'h0, 8'h00}) begin
      fails++;
      $display("[TB] FAIL reset_state: got %b/%h/%h expected %b/0/00",
               dut_flags(), queue_wr_data, res_idx, F_IDLE);
    end
`ifdef CIM_SEQ_PERF_CNT_EN
    check_int("reset_perf_busy", int'(perf_busy_cycles), 0);
    check_int("reset_perf_stall", int'(perf_stall_cycles), 0);
`endif
    @(posedge clk);
    #1;
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = 8'd1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (dut_flags() !== F_IDLE) begin
      fails++;
      $display("[TB] FAIL reset_beats_cmd: got %b expected %b", dut_flags(), F_IDLE);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    fill_patterns(0, 0);
    run_job(1, 4'h5, "basic");
    check_int("basic_res_cycle", obs_first[0], 14);
    check_int("basic_done_cycle", obs_done, 15);
    check_int("basic_load_pulses", obs_act, 1);
  endtask

  task automatic test_multi_vector();
    fill_patterns(0, 0);
    run_job(3, 4'(($urandom_range(0, 15))), "multi");
    check_int("multi_res0_cycle", obs_first[0], 14);
    check_int("multi_res1_cycle", obs_first[1], 27);
    check_int("multi_res2_cycle", obs_first[2], 40);
    check_int("multi_load_pulses", obs_act, 1);
    check_int("multi_done_cycle", obs_done, 41);
  endtask

  task automatic test_weight_stall();
    fill_patterns(0, 0);
    wv[5] = 1'b0;
    wv[6] = 1'b0;
    wv[7] = 1'b0;
    run_job(1, 4'hA, "stall");
    check_int("stall_res_cycle", obs_first[0], 17);
  endtask

  task automatic test_back_pressure();
    fill_patterns(0, 0);
    for (int c = 14; c < 19; c++) rr[c] = 1'b0;
    run_job(1, 4'h3, "backpressure");
    check_int("bp_res_cycle", obs_first[0], 14);
    check_int("bp_done_cycle", obs_done, 20);
  endtask

  task automatic test_zero_length();
    fill_patterns(0, 0);
    run_job(0, 4'hF, "zero_len");
    check_int("zero_done_cycle", obs_done, 1);
    check_int("zero_load_pulses", obs_act, 0);
  endtask

  task automatic test_reset_mid_drain();
    fill_patterns(0, 0);
    cmd_valid = 1'b1;
    cmd_len   = 8'd2;
    cmd_scale = 4'h7;
    wt_valid  = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (dut_flags() !== (F_BUSY | F_FLOP)) begin
      fails++;
      $display("[TB] FAIL mid_drain_state: got %b expected %b", dut_flags(), F_BUSY | F_FLOP);
    end
    reset     = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({dut_flags(), queue_wr_data, res_idx} !== {F_IDLE, 4'h0, 8'h00}) begin
      fails++;
      $display("[TB] FAIL after_reset_state: got %b/%h/%h expected %b/0/00",
               dut_flags(), queue_wr_data, res_idx, F_IDLE);
    end
`ifdef CIM_SEQ_PERF_CNT_EN
    check_int("after_reset_perf_busy", int'(perf_busy_cycles), 0);
    check_int("after_reset_perf_stall", int'(perf_stall_cycles), 0);
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      tests++;
      if (dut_flags() !== F_IDLE) begin
        fails++;
        $display("[TB] FAIL after_reset_idle%0d: got %b expected %b", i, dut_flags(), F_IDLE);
      end
    end
    @(posedge clk);
    #1;
    fill_patterns(0, 0);
    run_job(1, 4'hC, "after_reset_job");
    check_int("after_reset_res_cycle", obs_first[0], 14);
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 25; j++) begin
      fill_patterns(30, 30);
      run_job($urandom_range(0, 4), 4'($urandom_range(0, 15)), $sformatf("random%0d", j));
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = 8'd0;
    cmd_scale = 4'h0;
    wt_valid  = 1'b0;
    res_ready = 1'b0;
    test_reset();
    test_basic();
    test_multi_vector();
    test_weight_stall();
    test_back_pressure();
    test_zero_length();
    test_reset_mid_drain();
    test_random_jobs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
